// File: rtl/sipo_deserializer_if.sv
// Word handshake between the deserializer holding register and its consumer.
// The producer drives word and valid; the consumer drives ready.
interface sipo_deserializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] pout;
   logic             pout_valid;
   logic             pout_ready;

   modport master (
      output pout,
      output pout_valid,
      input  pout_ready
   );

   modport slave (
      input  pout,
      input  pout_valid,
      output pout_ready
   );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-deep valid/ready holding
// register and a sticky overrun flag for words lost to back-pressure.
module sipo_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sin,
   input  logic                     sin_en,
   input  logic                     frame_start,
   sipo_deserializer_if.master      out,
   output logic                     overrun,
   input  logic                     ovr_clr,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      S_EMPTY,
      S_FULL
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] sh;
   logic             cmpl;
   logic             load;
   logic             ovr_set;

   // A resync bit shifts into an empty register so the stale partial is gone.
   always_comb begin
      base = frame_start ? '0 : sreg;
      if (MSB_FIRST) sh = {base[WIDTH-2:0], sin};
      else           sh = {sin, base[WIDTH-1:1]};
   end

   assign cmpl = sin_en && !frame_start && (bit_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg    <= '0;
         bit_cnt <= '0;
      end else if (sin_en) begin
         sreg <= sh;
         if (frame_start) bit_cnt <= CW'(1);
         else if (cmpl)   bit_cnt <= '0;
         else             bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      ovr_set = 1'b0;
      unique case (state)
         S_EMPTY: begin
            if (cmpl) begin
               state_n = S_FULL;
               load    = 1'b1;
            end
         end
         S_FULL: begin
            if (cmpl && out.pout_ready) begin
               load = 1'b1;
            end else if (cmpl) begin
               ovr_set = 1'b1;
            end else if (out.pout_ready) begin
               state_n = S_EMPTY;
            end
         end
         default: state_n = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_EMPTY;
         out.pout <= '0;
         overrun  <= 1'b0;
      end else begin
         state <= state_n;
         if (load) out.pout <= sh;
         if (ovr_set)      overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

   assign out.pout_valid = (state == S_FULL);
endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: one MSB-first and one LSB-first instance share stimulus;
// a bit-list reference model predicts words, drops, flag and bit count.
module tb_sipo_deserializer;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sin = 1'b0;
   logic sin_en = 1'b0;
   logic frame_start = 1'b0;
   logic ovr_clr = 1'b0;
   logic ovr_m, ovr_l;
   logic [2:0] cnt_m, cnt_l;

   sipo_deserializer_if #(.WIDTH(W)) bm ();
   sipo_deserializer_if #(.WIDTH(W)) bl ();

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
      .frame_start(frame_start), .out(bm), .overrun(ovr_m),
      .ovr_clr(ovr_clr), .bit_cnt(cnt_m)
   );

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
      .frame_start(frame_start), .out(bl), .overrun(ovr_l),
      .ovr_clr(ovr_clr), .bit_cnt(cnt_l)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit done = 1'b0;

   bit bits[$];
   logic [W-1:0] qm[$];
   logic [W-1:0] ql[$];
   int occ = 0;
   bit ovr = 1'b0;
   int snap_occ = 0;
   bit snap_ovr = 1'b0;
   int snap_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic en, input logic fs,
                       input logic rdy, input logic clr);
      bit cmpl;
      bit pop;
      logic [W-1:0] wm, wl;
      @(negedge clk);
      #1;
      sin = s;
      sin_en = en;
      frame_start = fs;
      bm.pout_ready = rdy;
      bl.pout_ready = rdy;
      ovr_clr = clr;
      snap_occ = occ;
      snap_ovr = ovr;
      snap_cnt = bits.size();
      cmpl = 1'b0;
      wm = '0;
      wl = '0;
      if (en) begin
         if (fs) bits.delete();
         bits.push_back(s);
         if (bits.size() == W) begin
            cmpl = 1'b1;
            for (int i = 0; i < W; i++) begin
               wm = wm | (W'(bits[i]) << (W - 1 - i));
               wl = wl | (W'(bits[i]) << i);
            end
            bits.delete();
         end
      end
      pop = (occ > 0) && rdy;
      if (pop) occ = occ - 1;
      if (cmpl && occ > 0) begin
         ovr = 1'b1;
      end else begin
         if (cmpl) begin
            qm.push_back(wm);
            ql.push_back(wl);
            occ = occ + 1;
         end
         if (clr) ovr = 1'b0;
      end
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit msb,
                            input logic fs0, input logic rdy,
                            input logic rdy_last, input logic clr_last);
      logic b;
      for (int i = 0; i < W; i++) begin
         b = msb ? w[W-1-i] : w[i];
         step(b, 1'b1, fs0 && (i == 0), (i == W - 1) ? rdy_last : rdy,
              (i == W - 1) ? clr_last : 1'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      sin_en = 1'b0;
      frame_start = 1'b0;
      bm.pout_ready = 1'b0;
      bl.pout_ready = 1'b0;
      ovr_clr = 1'b0;
      #1;
      chk("rst_pout_m", int'(bm.pout), 0);
      chk("rst_valid_m", int'(bm.pout_valid), 0);
      chk("rst_ovr_m", int'(ovr_m), 0);
      chk("rst_cnt_m", int'(cnt_m), 0);
      chk("rst_pout_l", int'(bl.pout), 0);
      chk("rst_valid_l", int'(bl.pout_valid), 0);
      chk("rst_ovr_l", int'(ovr_l), 0);
      chk("rst_cnt_l", int'(cnt_l), 0);
      bits.delete();
      qm.delete();
      ql.delete();
      occ = 0;
      ovr = 1'b0;
      snap_occ = 0;
      snap_ovr = 1'b0;
      snap_cnt = 0;
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor samples just before each rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!rst && !done) begin
            chk("valid_m", int'(bm.pout_valid), snap_occ);
            chk("valid_l", int'(bl.pout_valid), snap_occ);
            chk("ovr_m", int'(ovr_m), int'(snap_ovr));
            chk("ovr_l", int'(ovr_l), int'(snap_ovr));
            chk("cnt_m", int'(cnt_m), snap_cnt);
            chk("cnt_l", int'(cnt_l), snap_cnt);
            if (bm.pout_valid) begin
               if (qm.size() == 0) chk("pout_m_unexpected", 1, 0);
               else begin
                  chk("pout_m", int'(bm.pout), int'(qm[0]));
                  if (bm.pout_ready) void'(qm.pop_front());
               end
            end
            if (bl.pout_valid) begin
               if (ql.size() == 0) chk("pout_l_unexpected", 1, 0);
               else begin
                  chk("pout_l", int'(bl.pout), int'(ql[0]));
                  if (bl.pout_ready) void'(ql.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bm.pout_ready = 1'b0;
      bl.pout_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;

      send_word(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      send_word(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_word(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      send_word(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_word(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_word(8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 800; i++) begin
         step(1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 15) == 0));
      end

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #4;
      done = 1'b1;
      chk("drain_m", qm.size(), 0);
      chk("drain_l", ql.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
